chunked_add_sub: RTL and testbench
==================================

# chunked_add_sub

Parametrised, multi-cycle adder/subtractor that computes a WIDTH-bit A±B one CHUNK-bit slice per clock, rippling the carry through a register between slices. It is the sequential, width-generic successor to the team's 4-bit ripple-carry adder. It is intended for datapaths where a full-width combinational carry chain would not close timing. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle (1..WIDTH); NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1; cin ignored).
- cin  in  1  carry-in for add.
- out_valid  out  1  result registers hold a new result.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
  - latch a, b_eff (b, or ~b when sub=1), and carry (cin, or 1 when sub=1);
  - clear slice index to 0; go to RUN.
- RUN: in_ready=0. Each cycle:
  - add slice idx of a and b_eff plus the carry register (CHUNK-bit ripple);
  - write the slice into sum[idx*CHUNK +: CHUNK]; update the carry register; idx++.
  - On the last slice (idx=NCHUNK−1), also capture cout and ovf (carry into MSB taken from the final slice's internal ripple), compute zero from the full sum, and go to DONE.
- DONE: out_valid=1; sum/cout/ovf/zero stable. On out_ready, go to IDLE. Operands are not accepted in DONE.
- a, b, sub and cin are don't-care after acceptance; changes during RUN/DONE have no effect.
- sum is updated slice by slice during RUN and is only meaningful while out_valid=1.
- CHUNK==WIDTH (NCHUNK=1) is legal: RUN lasts one cycle.
- Illegal parameter combinations (WIDTH % CHUNK ≠ 0, CHUNK=0) are rejected at elaboration.

## Timing
- Reset values (async on rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, internal carry and idx = 0.
- Reset asserted mid-RUN or in DONE aborts the operation; no out_valid is produced for it.
- Latency: operands accepted at edge E; slice i is written at edge E+1+i; out_valid=1 after edge E+NCHUNK.
- With out_ready held high, DONE lasts 1 cycle, IDLE is re-entered after edge E+NCHUNK+1, and the next accept happens at edge E+NCHUNK+2.
- Minimum issue interval: NCHUNK+2 cycles.
- Backpressure: out_valid stays high and all outputs stay frozen for any number of cycles while out_ready=0.
- in_ready is a registered function of state only; it has no combinational path from in_valid or out_ready.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Reset: rst_n low → in_ready=1, out_valid=0, sum=0x0000, flags 0. Add a=0x00FF, b=0x0001, cin=0 → out_valid exactly 4 cycles after accept, sum=0x0100, cout=0, ovf=0, zero=0.
- Carry chain and carry-in:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0, zero=1.
  - 0x1234+0x1111 with cin=1 → 0x2346.
- Signed overflow:
  - 0x7FFF+0x0001 → 0x8000, ovf=1, cout=0.
  - sub 0x8000−0x0001 → 0x7FFF, ovf=1, cout=1.
  - sub 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0.
- Handshake: hold out_ready=0 for 5 cycles in DONE → outputs frozen and in_ready=0 throughout. Toggle a/b during RUN → result unaffected. Back-to-back ops with in_valid and out_ready held high → accepts spaced exactly 6 cycles.
- Reset mid-RUN: pull rst_n low 2 cycles after accept → immediate return to reset values, no out_valid. The next op completes correctly.
- Parameter sweep: CHUNK ∈ {1, 8, 16}, 1000 random a/b/sub/cin each, results compared to a behavioural full-width model. Latency must equal WIDTH/CHUNK in every case.

Source files
------------

// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle WIDTH-bit adder/subtractor that adds one CHUNK-bit slice per clock,
// carrying between slices through a register so no full-width carry chain exists.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, sub, cin      operands; sub=1 computes a - b (cin ignored), sub=0 computes a + b + cin
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   sum, cout, ovf, zero result and flags; cout=1 on sub means no borrow
module chunked_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Guarded so an illegal CHUNK still reaches the elaboration error below.
  localparam int unsigned CW     = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned NCHUNK = WIDTH / CW;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK == 0) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : gen_param_check
    $error("chunked_add_sub: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;      // b already inverted for subtraction
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [31:0]       base;
  logic [CW-1:0]     a_s, b_s, s;
  logic              c, c_msb;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    // Bit-level ripple across the current slice; c_msb ends as the carry into the slice MSB,
    // which on the last slice is the carry into the word MSB.
    base  = 32'(idx_q) * CW;
    a_s   = a_q[base +: CW];
    b_s   = b_q[base +: CW];
    c     = carry_q;
    c_msb = carry_q;
    s     = '0;
    for (int i = 0; i < CW; i++) begin
      c_msb = c;
      s[i]  = a_s[i] ^ b_s[i] ^ c;
      c     = (a_s[i] & b_s[i]) | (c & (a_s[i] ^ b_s[i]));
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: CW] = s;
        carry_d           = c;
        idx_d             = idx_q + 1'b1;
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          cout_d  = c;
          ovf_d   = c ^ c_msb;
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Decoded from the state register only: no path from in_valid or out_ready.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Testbench for chunked_add_sub: directed vector table and handshake sequences on a CHUNK=4
// instance, plus a random sweep over CHUNK = 4, 1, 8, 16 against a full-width arithmetic model.
module tb_chunked_add_sub;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        sub, cin;

  logic        in_ready_w  [NDUT];
  logic        out_valid_w [NDUT];
  logic [15:0] sum_w       [NDUT];
  logic        cout_w      [NDUT];
  logic        ovf_w       [NDUT];
  logic        zero_w      [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int unsigned CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
    chunked_add_sub #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .sum       (sum_w[g]),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g]),
      .zero      (zero_w[g])
    );
  end

  function automatic int nch(input int g);
    case (g)
      0:       return 4;
      1:       return 16;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: full-width arithmetic; overflow from operand/result signs.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic msub, input logic mcin);
    logic [16:0] full;
    logic [15:0] bb;
    logic        ov;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
    ov   = (ma[15] == bb[15]) && (full[15] != ma[15]);
    return {ov, (full[15:0] == 16'd0), full[16], full[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op to DUT 0 and return cycles from the accept edge until out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                        input logic tcin, input bit scramble, output int lat);
    int w;
    w = 0;
    while (!in_ready_w[0] && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready_w[0]) check("in_ready_timeout", 32'(in_ready_w[0]), 32'd1);
    a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      tick();
      lat++;
      if (out_valid_w[0]) break;
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] s;
    logic        co, ov, z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat;
    int          acc[$];
    int          cyc;
    logic [18:0] m;
    bit          done[NDUT];
    bit          all;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 16'h0007, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready[%0d]", d), 32'(in_ready_w[d]), 32'd1);
      check($sformatf("rst_out_valid[%0d]", d), 32'(out_valid_w[d]), 32'd0);
      check($sformatf("rst_sum[%0d]", d), 32'(sum_w[d]), 32'd0);
      check($sformatf("rst_flags[%0d]", d), {29'd0, cout_w[d], ovf_w[d], zero_w[d]}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(sum_w[0]), 32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(cout_w[0]), 32'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(ovf_w[0]), 32'(vecs[i].ov));
      check($sformatf("vec%0d_zero", i), 32'(zero_w[0]), 32'(vecs[i].z));
      tick();
    end

    // Backpressure: result held 5 cycles, new operands refused
    out_ready = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd4);
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_out_valid_%0d", k), 32'(out_valid_w[0]), 32'd1);
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready_w[0]), 32'd0);
      check($sformatf("bp_sum_%0d", k), 32'(sum_w[0]), 32'h5555);
      check($sformatf("bp_flags_%0d", k), {29'd0, cout_w[0], ovf_w[0], zero_w[0]}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
    check("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);

    // Operands changing after acceptance must not matter
    run_op(16'h0F0F, 16'h1010, 1'b0, 1'b1, 1'b1, lat);
    check("scramble_latency", 32'(lat), 32'd4);
    check("scramble_sum", 32'(sum_w[0]), 32'h1F20);
    tick();

    // Back-to-back with in_valid and out_ready high: accepts every 6 cycles
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (cyc = 0; cyc < 26; cyc++) begin
      if (in_ready_w[0]) acc.push_back(cyc);
      tick();
    end
    in_valid = 1'b0;
    check("b2b_accept_count", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++)
      check($sformatf("b2b_spacing_%0d", i), 32'(acc[i] - acc[i-1]), 32'd6);
    repeat (8) tick();

    // Reset two cycles into RUN aborts the op
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready_w[0]), 32'd1);
    check("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
    check("midrst_sum", 32'(sum_w[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 2) rst_n = 1'b1;
      check($sformatf("midrst_no_valid_%0d", k), 32'(out_valid_w[0]), 32'd0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
    check("postrst_latency", 32'(lat), 32'd4);
    check("postrst_sum", 32'(sum_w[0]), 32'h0100);
    tick();

    // Random sweep across all chunk sizes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int it = 0; it < 1000; it++) begin
      for (int d = 0; d < NDUT; d++) begin
        if (!in_ready_w[d]) check($sformatf("rnd%0d_idle[%0d]", it, d), 32'(in_ready_w[d]), 32'd1);
        done[d] = 1'b0;
      end
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      m = model(a, b, sub, cin);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        all = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
          if (!done[d] && out_valid_w[d]) begin
            done[d] = 1'b1;
            check($sformatf("rnd%0d_lat[%0d]", it, d), 32'(k), 32'(nch(d)));
            check($sformatf("rnd%0d_sum[%0d]", it, d), 32'(sum_w[d]), 32'(m[15:0]));
            check($sformatf("rnd%0d_cout[%0d]", it, d), 32'(cout_w[d]), 32'(m[16]));
            check($sformatf("rnd%0d_zero[%0d]", it, d), 32'(zero_w[d]), 32'(m[17]));
            check($sformatf("rnd%0d_ovf[%0d]", it, d), 32'(ovf_w[d]), 32'(m[18]));
          end
          all &= done[d];
        end
        if (all) break;
      end
      for (int d = 0; d < NDUT; d++)
        if (!done[d]) check($sformatf("rnd%0d_timeout[%0d]", it, d), 32'(done[d]), 32'd1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
